// File: rtl/circular_unshift_pipe_if.sv
// circular_unshift_pipe_if: valid/ready stream bundle carrying lists into and out of the unshift pipe
interface circular_unshift_pipe_if #(
  parameter int SIZE = 257,
  parameter int WIDTH = 32,
  parameter int AMT_W = 9
);
  logic in_valid;
  logic in_ready;
  logic [SIZE*WIDTH-1:0] in_list;
  logic [AMT_W-1:0] in_amount;
  logic out_valid;
  logic out_ready;
  logic [SIZE*WIDTH-1:0] out_list;
  modport master (
    output in_valid, in_list, in_amount, out_ready,
    input in_ready, out_valid, out_list
  );
  modport slave (
    input in_valid, in_list, in_amount, out_ready,
    output in_ready, out_valid, out_list
  );
endinterface

// File: rtl/circular_unshift_pipe.sv
// circular_unshift_pipe: pipelined circular rotator that undoes a write-side index shift, out[i] = in[(i+amount) mod SIZE]
module circular_unshift_pipe #(
  parameter int SIZE = 257,
  parameter int WIDTH = 32,
  parameter int AMT_W = 9
) (
  input logic clk,
  input logic rst,
  circular_unshift_pipe_if.slave bus
);
  localparam int LW = SIZE * WIDTH;
  logic stall;
  logic valid_q [AMT_W];
  logic [LW-1:0] list_q [AMT_W];
  logic [AMT_W-1:0] amt_q [AMT_W];
  logic s_valid [AMT_W];
  logic [LW-1:0] s_list [AMT_W];
  logic [AMT_W-1:0] s_amt [AMT_W];
  logic [LW-1:0] list_d [AMT_W];
  assign stall = valid_q[AMT_W-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign bus.out_valid = valid_q[AMT_W-1];
  assign bus.out_list = list_q[AMT_W-1];
  assign s_valid[0] = bus.in_valid;
  assign s_list[0] = bus.in_list;
  assign s_amt[0] = bus.in_amount;
  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int R = int'((64'd1 << k) % SIZE);
    if (k > 0) begin : g_link
      assign s_valid[k] = valid_q[k-1];
      assign s_list[k] = list_q[k-1];
      assign s_amt[k] = amt_q[k-1];
    end
    if (R == 0) begin : g_pass
      assign list_d[k] = s_list[k];
    end else begin : g_rot
      assign list_d[k] = s_amt[k][k] ? ((s_list[k] >> (R * WIDTH)) | (s_list[k] << ((SIZE - R) * WIDTH))) : s_list[k];
    end
    // advance this stage with the whole pipe unless the output is stalled; reset flushes it
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        list_q[k] <= '0;
        amt_q[k] <= '0;
      end else if (!stall) begin
        valid_q[k] <= s_valid[k];
        list_q[k] <= list_d[k];
        amt_q[k] <= s_amt[k];
      end
    end
  end
endmodule

// File: tb/tb_circular_unshift_pipe.sv
// tb_circular_unshift_pipe: randomized and directed checks of the unshift pipe against a queue-based reference model
module tb_circular_unshift_pipe;
  localparam int SIZE = 257;
  localparam int WIDTH = 32;
  localparam int AMT_W = 9;
  localparam int LW = SIZE * WIDTH;
  typedef logic [LW-1:0] lst_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  bit rnd = 0;

  circular_unshift_pipe_if #(.SIZE(SIZE), .WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();
  circular_unshift_pipe #(.SIZE(SIZE), .WIDTH(WIDTH), .AMT_W(AMT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] el(input lst_t l, input int i);
    return l[i*WIDTH +: WIDTH];
  endfunction

  function automatic lst_t unshift(input lst_t l, input int a);
    lst_t r;
    int m;
    m = a % SIZE;
    for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = l[((i + m) % SIZE)*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic lst_t fshift(input lst_t l, input int s);
    lst_t r;
    for (int j = 0; j < SIZE; j++) r[((j + s) % SIZE)*WIDTH +: WIDTH] = l[j*WIDTH +: WIDTH];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag, input lst_t obs, input lst_t exp);
    int idx;
    checks++;
    assert (obs === exp) else begin
      errors++;
      idx = 0;
      for (int i = SIZE - 1; i >= 0; i--) if (obs[i*WIDTH +: WIDTH] !== exp[i*WIDTH +: WIDTH]) idx = i;
      $error("FAIL %s elem %0d got %h want %h", tag, idx, el(obs, idx), el(exp, idx));
    end
  endtask

  lst_t exp_q[$];
  int age_q[$];
  logic [WIDTH-1:0] firsts[$];
  lst_t last_out;
  int out_cnt = 0;
  int run = 0;
  int max_run = 0;
  bit prev_adv = 0;
  bit exp_v;

  always @(negedge clk) begin
    if (prev_adv) foreach (age_q[i]) age_q[i]++;
    if (rst) begin
      exp_q.delete();
      age_q.delete();
      prev_adv = 0;
    end else begin
      exp_v = exp_q.size() > 0 && age_q[0] == AMT_W;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
      chk("in_ready", 32'(bus.in_ready), 32'(!(exp_v && !bus.out_ready)));
      run = bus.out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (exp_v && bus.out_ready) begin
        chk_list("out_list", bus.out_list, exp_q[0]);
        last_out = bus.out_list;
        firsts.push_back(el(bus.out_list, 0));
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
        out_cnt++;
      end
      if (bus.in_valid && !(exp_v && !bus.out_ready)) begin
        exp_q.push_back(unshift(bus.in_list, int'(bus.in_amount)));
        age_q.push_back(0);
      end
      prev_adv = !(exp_v && !bus.out_ready);
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) begin
      if (rnd) bus.out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input lst_t l, input int a);
    int t;
    t = 0;
    bus.in_valid = 1;
    bus.in_list = l;
    bus.in_amount = AMT_W'(a);
    if (rnd) bus.out_ready = 1'($urandom);
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(posedge clk);
      #1;
      if (rnd) bus.out_ready = 1'($urandom);
      @(negedge clk);
      t++;
    end
    chk("send_wait", 32'(t < 200), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
  endtask

  task automatic latency(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 30);
    chk(tag, 32'(n), 32'(AMT_W));
    @(posedge clk);
    #1;
  endtask

  lst_t ramp, r, snap;
  int cnt0;
  int shifts[4] = '{0, 1, 128, 256};

  initial begin
    for (int i = 0; i < SIZE; i++) ramp[i*WIDTH +: WIDTH] = WIDTH'(i);
    rst = 1;
    bus.in_valid = 0;
    bus.in_list = '0;
    bus.in_amount = '0;
    bus.out_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1;
    bus.in_list = ramp;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_list("rst_out_list", bus.out_list, '0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 0;
    bus.in_valid = 0;
    idle(2);

    send(ramp, 0);
    latency("latency_amt0");
    idle(1);
    chk_list("identity", last_out, ramp);

    send(ramp, 1);
    idle(12);
    chk("a1_out0", 32'(el(last_out, 0)), 32'd1);
    chk("a1_out255", 32'(el(last_out, 255)), 32'd256);
    chk("a1_out256", 32'(el(last_out, 256)), 32'd0);

    send(ramp, 256);
    idle(12);
    chk("a256_out0", 32'(el(last_out, 0)), 32'd256);
    chk("a256_out1", 32'(el(last_out, 1)), 32'd0);

    send(ramp, 300);
    idle(12);
    chk_list("a300_eq_a43", last_out, unshift(ramp, 43));
    chk("a300_out0", 32'(el(last_out, 0)), 32'd43);
    chk("a300_out213", 32'(el(last_out, 213)), 32'd256);
    chk("a300_out214", 32'(el(last_out, 214)), 32'd0);

    max_run = 0;
    firsts.delete();
    for (int n = 0; n < 20; n++) send(ramp, n);
    idle(15);
    chk("stream_run", 32'(max_run), 32'd20);
    chk("stream_cnt", 32'(firsts.size()), 32'd20);
    for (int n = 0; n < 20 && n < firsts.size(); n++) chk("stream_order", 32'(firsts[n]), 32'(n));

    firsts.delete();
    rnd = 1;
    for (int n = 0; n < 20; n++) send(ramp, n);
    idle(60);
    rnd = 0;
    bus.out_ready = 1;
    idle(15);
    chk("rnd_cnt", 32'(firsts.size()), 32'd20);
    for (int n = 0; n < 20 && n < firsts.size(); n++) chk("rnd_order", 32'(firsts[n]), 32'(n));

    for (int n = 0; n < 9; n++) begin
      for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = $urandom;
      send(r, $urandom_range(0, 511));
    end
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.in_list = ramp;
    bus.in_amount = AMT_W'(7);
    @(negedge clk);
    chk("stall_full", 32'(bus.out_valid), 32'd1);
    snap = bus.out_list;
    cnt0 = out_cnt;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk_list("stall_hold", bus.out_list, snap);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    idle(15);
    chk("stall_drain", 32'(out_cnt - cnt0), 32'd10);

    foreach (shifts[s]) begin
      for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = $urandom;
      send(fshift(r, shifts[s]), shifts[s]);
      idle(12);
      chk_list("round_trip", last_out, r);
    end

    for (int n = 0; n < 4; n++) send(ramp, n + 1);
    cnt0 = out_cnt;
    rst = 1;
    bus.in_valid = 1;
    bus.in_list = ramp;
    @(posedge clk);
    #1;
    rst = 0;
    bus.in_valid = 0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk_list("mid_rst_list", bus.out_list, '0);
    @(posedge clk);
    #1;
    idle(15);
    chk("no_stale", 32'(out_cnt - cnt0), 32'd0);
    send(ramp, 5);
    latency("latency_post_rst");
    idle(2);
    chk_list("post_rst_list", last_out, unshift(ramp, 5));
    chk("post_rst_out0", 32'(el(last_out, 0)), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/circular_unshift_pipe.md
Name: circular_unshift_pipe

Overview:
- Pipelined, runtime-programmable circular rotator for SIZE-element coefficient lists. It performs the inverse of the fixed-SHIFT circular shift stage.
- Element at index j of the input moves to index (j - amount) mod SIZE, i.e. out[i] = in[(i + amount) mod SIZE].
- Sits on the read-back side of the non-power-of-two NTT datapath. It undoes index rotations applied on the write side before coefficients leave the core.
- Uses a valid/ready stream interface with full-pipeline backpressure.

Parameters:
- SIZE, 257, number of elements per list (any value >= 2, need not be a power of two)
- WIDTH, 32, bits per element
- AMT_W, 9, width of the rotation amount; must satisfy 2^AMT_W >= SIZE

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input list and amount are valid
- in_ready  output  1  pipeline can accept input this cycle
- in_list  input  SIZE*WIDTH  input list, element i at bits [(i+1)*WIDTH-1 : i*WIDTH]
- in_amount  input  AMT_W  rotation amount, taken modulo SIZE
- out_valid  output  1  out_list holds a result
- out_ready  input  1  downstream accepts result
- out_list  output  SIZE*WIDTH  rotated list, same packing as in_list

Behaviour:
- Structure: AMT_W registered stages, k = 0..AMT_W-1.
  - Stage k rotates its list by R_k = (2^k mod SIZE) toward index 0 when bit k of the carried amount is set; otherwise it passes the list through.
  - Each stage registers {valid_k, list_k, amount_k}.
  - The amount travels with the data; stage k uses only bit k.
- Total rotation = sum of R_k for set bits, mod SIZE = in_amount mod SIZE. Amounts >= SIZE are legal and wrap; no error flag.
- Global stall: stall = out_valid & ~out_ready.
  - When stall = 1, no stage register changes.
  - When stall = 0, all stages advance by one.
- in_ready = ~stall, combinational. An input is accepted on a cycle where in_valid & in_ready.
- Bubbles: when stall = 0 and in_valid = 0, a bubble (valid = 0) enters stage 0. Bubbles are not squeezed out.
- Latency: an accepted input appears on out_valid/out_list exactly AMT_W cycles later when no stall occurs. Each stall cycle adds exactly one cycle.
- Throughput: one list per cycle when out_ready is held high.
- Ordering: results leave in acceptance order, with no loss or duplication under any out_ready pattern.
- out_list / out_valid are driven directly from the last stage registers; there is no combinational path from in_* to out_*.
- Reset (rst = 1 at a clock edge):
  - All valid bits go to 0.
  - All list and amount registers go to 0, so out_valid = 0 and out_list = 0 the following cycle.
  - Reset overrides stall and in_valid.
  - Reset mid-operation discards all in-flight lists.
- While rst is high, in_ready = 1 (stall is 0 because out_valid is 0); inputs presented are discarded.
- Simultaneous accept and output handshake in the same cycle is normal pipelined advance.
- amount = 0 is identity. amount = SIZE-1 equals rotation by -1: out[0] = in[SIZE-1].

Test Plan:
- Defaults, in_list element i = i, amount 0, out_ready = 1 -> out_valid rises exactly 9 cycles after acceptance; out_list element i = i.
- amount 1 -> out[0] = 1, out[255] = 256, out[256] = 0. Amount 256 -> out[0] = 256, out[1] = 0. Amount 300 -> identical to amount 43: out[0] = 43, out[213] = 256, out[214] = 0.
- Back-to-back stream of 20 lists, amounts 0..19, out_ready = 1 -> 20 consecutive out_valid cycles, list n has out[0] = n. Then repeat with out_ready toggling pseudo-randomly -> same 20 results in order, and in_ready = 0 exactly on cycles with out_valid & ~out_ready.
- Fill pipeline, hold out_ready = 0 for 5 cycles -> out_list stable and in_ready = 0 throughout; on release, the remaining results drain one per cycle.
- Round trip: random list through the fixed shift stage (SHIFT = s, shift = 1) for s in {0, 1, 128, 256}, then into this block with amount s -> out_list equals the original list.
- Assert rst for one cycle with 4 lists in flight -> next cycle out_valid = 0 and out_list = 0. No stale result ever appears; a new input accepted after reset emerges 9 cycles later.
